multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore FSM that sequences a multi-cycle MIPS datapath with one shared instruction/data async_mem,
//  one ALU and one register file. Decodes op/func, steps each instruction through FETCH..writeback,
//  and drives every datapath mux select and write enable. Also counts retired instructions.
//  Same ISA as the single-cycle core: add(u) sub(u) and or xor nor slt sltu; beq bne lw sw
//  addi(u) slti sltiu andi ori xori lui.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  op         in   6   IR[31:26] (from instruction register, stable after FETCH)
//  func       in   6   IR[5:0]
//  alu_zero   in   1   ALU Z flag, valid in BRANCH state
//  pc_write   out  1   PC load enable (unconditional OR taken-branch, already combined)
//  iord       out  1   memory address select: 0 PC, 1 ALUOut
//  mem_write  out  1   memory write enable
//  ir_write   out  1   instruction register load
//  mdr_write  out  1   memory data register load
//  reg_dst    out  1   1 rd (IR[15:11]), 0 rt (IR[20:16])
//  mem_to_reg out  1   1 MDR, 0 ALUOut
//  reg_write  out  1   register file write enable
//  alu_src_a  out  1   0 PC, 1 register A
//  alu_src_b  out  2   00 reg B, 01 const 4, 10 Imm32, 11 Imm32<<2
//  pc_src     out  1   0 ALU result, 1 ALUOut (branch target)
//  sz_en      out  1   1 sign-extend imm, 0 zero-extend
//  alu_op     out  4   ADD0 SUB1 SLT2 SLTU3 AND4 OR5 NOR6 XOR7 LUI8
//  illegal    out  1   one-cycle pulse in DECODE for unsupported op/func
//  retired    out  CNT_W  count of completed instructions
//  state      out  4   current state (debug)
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH.
//  FETCH : iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=0, pc_write=1 -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, sz_en=1, ADD (branch target into ALUOut). Next:
//   lw/sw->MEMADR; R-type legal func->REXEC; I-ALU->IEXEC; beq/bne->BRANCH; else illegal=1 ->FETCH.
//  MEMADR: alu_src_a=1, alu_src_b=10, sz_en=1, ADD -> MEMRD (lw) | MEMWR (sw).
//  MEMRD : iord=1, mdr_write=1 -> MEMWB.  MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEMWR : iord=1, mem_write=1 -> FETCH.
//  REXEC : alu_src_a=1, alu_src_b=00, alu_op from func -> RWB. RWB: reg_dst=1, mem_to_reg=0, reg_write=1.
//  IEXEC : alu_src_a=1, alu_src_b=10; sz_en=1 for addi/slti, 0 for addiu/sltiu/andi/ori/xori/lui;
//          alu_op ADD/ADD/SLT/SLTU/AND/OR/XOR/LUI -> IWB. IWB: reg_dst=0, mem_to_reg=0, reg_write=1.
//  BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=1;
//          pc_write = (beq & alu_zero) | (bne & ~alu_zero) -> FETCH.
//  Unlisted outputs in a state: write enables 0, selects 0, alu_op ADD (no X on outputs).
//  Latency (cycles incl. FETCH): lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, illegal 2.
//  retired += 1 on the cycle leaving MEMWB, MEMWR, RWB, IWB, BRANCH (taken or not); not on illegal.
//  Reset: while reset=1 all enables (pc_write, ir_write, mdr_write, mem_write, reg_write) forced 0,
//   illegal=0; on the edge: state<=FETCH, retired<=0. Reset mid-instruction abandons it, no write.
//  op/func sampled only in DECODE/exec states; X on op outside DECODE must not change state.
// STRUCTURE
//  Shared package mips_pkg: ALU op codes, opcode/func constants, state encoding, alu_src_b codes.
//  One sub-module: mips_alu_dec (func -> alu_op + legal flag), combinational, used in REXEC/DECODE.
//  State reg + counter in this module; outputs decoded from state (and op/func/alu_zero).
// TESTING
//  reset 3 cycles then release -> state=FETCH, retired=0, no write enable high during reset.
//  add $3,$1,$2 (op 0, func 20h) -> 4 cycles FETCH,DECODE,REXEC,RWB; reg_dst=1 reg_write=1 in RWB; retired=1.
//  lw then sw -> 5 and 4 cycles; mdr_write in MEMRD, mem_write only in MEMWR with iord=1.
//  beq with alu_zero=1 -> pc_write=1 pc_src=1 in BRANCH; bne with alu_zero=1 -> pc_write=0.
//  op=3Fh and R-type func=00h -> illegal pulse in DECODE, back to FETCH, retired unchanged.
//  reset asserted in MEMWR -> mem_write=0 that cycle, FETCH next; retired wraps at 2^CNT_W-1 with CNT_W=4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: ALU ops, opcodes, funcs, FSM states.
package mips_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_NOR  = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_LUI  = 4'd8
   } alu_op_t;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_REXEC  = 4'd6,
      ST_RWB    = 4'd7,
      ST_IEXEC  = 4'd8,
      ST_IWB    = 4'd9,
      ST_BRANCH = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   function automatic logic is_i_alu(input logic [5:0] op);
      return (op >= OP_ADDI) && (op <= OP_LUI);
   endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type function decoder: maps func to an ALU operation and flags unsupported encodings.
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] func,
   output alu_op_t    alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (func)
         FN_ADD, FN_ADDU: alu_op = ALU_ADD;
         FN_SUB, FN_SUBU: alu_op = ALU_SUB;
         FN_AND:          alu_op = ALU_AND;
         FN_OR:           alu_op = ALU_OR;
         FN_XOR:          alu_op = ALU_XOR;
         FN_NOR:          alu_op = ALU_NOR;
         FN_SLT:          alu_op = ALU_SLT;
         FN_SLTU:         alu_op = ALU_SLTU;
         default:         legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath, plus a retired-instruction counter.
//  state  | meaning
//  FETCH  | read IR from mem[PC], PC <= PC+4
//  DECODE | decode op/func, precompute branch target into ALUOut
//  MEMADR | ALUOut <= A + imm for lw/sw
//  MEMRD  | MDR <= mem[ALUOut]
//  MEMWB  | rt <= MDR
//  MEMWR  | mem[ALUOut] <= B
//  REXEC  | ALUOut <= A op B
//  RWB    | rd <= ALUOut
//  IEXEC  | ALUOut <= A op imm
//  IWB    | rt <= ALUOut
//  BRANCH | compare A,B; PC <= target when taken
module multi_cycle_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             alu_zero,
   output logic             pc_write,
   output logic             iord,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             pc_src,
   output logic             sz_en,
   output logic [3:0]       alu_op,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   state_t  state_q;
   state_t  next_state;
   alu_op_t alu_sel;
   alu_op_t r_alu_op;
   logic    r_legal;
   logic    retire;

   mips_alu_dec u_alu_dec (
      .func   (func),
      .alu_op (r_alu_op),
      .legal  (r_legal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         retired <= '0;
      end else begin
         state_q <= next_state;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state_q;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_src     = 1'b0;
      sz_en      = 1'b0;
      alu_sel    = ALU_ADD;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            next_state = ST_DECODE;
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            sz_en     = 1'b1;
            if (op == OP_LW || op == OP_SW)        next_state = ST_MEMADR;
            else if (op == OP_RTYPE && r_legal)    next_state = ST_REXEC;
            else if (is_i_alu(op))                 next_state = ST_IEXEC;
            else if (op == OP_BEQ || op == OP_BNE) next_state = ST_BRANCH;
            else begin
               illegal    = 1'b1;
               next_state = ST_FETCH;
            end
         end
         ST_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            sz_en      = 1'b1;
            next_state = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            iord       = 1'b1;
            mdr_write  = 1'b1;
            next_state = ST_MEMWB;
         end
         ST_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         ST_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         ST_REXEC: begin
            alu_src_a  = 1'b1;
            alu_sel    = r_alu_op;
            next_state = ST_RWB;
         end
         ST_RWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         ST_IEXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = ST_IWB;
            case (op)
               OP_ADDI:  begin alu_sel = ALU_ADD; sz_en = 1'b1; end
               OP_SLTI:  begin alu_sel = ALU_SLT; sz_en = 1'b1; end
               OP_SLTIU: alu_sel = ALU_SLTU;
               OP_ANDI:  alu_sel = ALU_AND;
               OP_ORI:   alu_sel = ALU_OR;
               OP_XORI:  alu_sel = ALU_XOR;
               OP_LUI:   alu_sel = ALU_LUI;
               default:  alu_sel = ALU_ADD;
            endcase
         end
         ST_IWB: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_sel    = ALU_SUB;
            pc_src     = 1'b1;
            pc_write   = (op == OP_BEQ) ? alu_zero : ~alu_zero;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         default: next_state = ST_FETCH;
      endcase
      // Reset must abandon any in-flight instruction without side effects.
      if (reset) begin
         pc_write  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         mdr_write = 1'b0;
         reg_write = 1'b0;
         illegal   = 1'b0;
      end
   end

   assign alu_op = alu_sel;
   assign state  = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl against an instruction-level reference model.
module tb_multi_cycle_ctrl;
   import mips_pkg::*;

   localparam int CNT_W = 4;
   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_ILL = 5;

   logic             clk = 1'b0;
   logic             reset, alu_zero;
   logic [5:0]       op, func;
   logic             pc_write, iord, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg;
   logic             reg_write, alu_src_a, pc_src, sz_en, illegal;
   logic [1:0]       alu_src_b;
   logic [3:0]       alu_op, state;
   logic [CNT_W-1:0] retired;

   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_ret = '0;
   logic [5:0]       r_funcs [10];
   logic [5:0]       i_ops [8];

   always #5 clk = ~clk;

   multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .func(func), .alu_zero(alu_zero),
      .pc_write(pc_write), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .mdr_write(mdr_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_src(pc_src), .sz_en(sz_en), .alu_op(alu_op), .illegal(illegal),
      .retired(retired), .state(state)
   );

   // Instruction class from the ISA list; unknown op/func is illegal.
   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h23) return K_LW;
      if (o == 6'h2B) return K_SW;
      if (o == 6'h04 || o == 6'h05) return K_BR;
      if (o >= 6'h08 && o <= 6'h0F) return K_I;
      if (o == 6'h00 && ((f >= 6'h20 && f <= 6'h27) || f == 6'h2A || f == 6'h2B)) return K_R;
      return K_ILL;
   endfunction

   function automatic int n_cycles(input int kind);
      case (kind)
         K_LW:    return 5;
         K_SW, K_R, K_I: return 4;
         K_BR:    return 3;
         default: return 2;
      endcase
   endfunction

   // Expected control word for cycle c of an instruction:
   // {pc_write,iord,mem_write,ir_write,mdr_write,reg_dst,mem_to_reg,reg_write,
   //  alu_src_a,alu_src_b,pc_src,sz_en,alu_op,illegal}
   function automatic logic [17:0] expect_vec(input int kind, input int c, input logic [5:0] o,
                                              input logic [5:0] f, input logic z, input logic rst);
      logic pcw = 0, io = 0, mw = 0, irw = 0, mdw = 0, rd = 0, m2r = 0, rw = 0;
      logic sa = 0, pcs = 0, sz = 0, ill = 0;
      logic [1:0] sb = 0;
      logic [3:0] ao = 0;
      if (c == 0) begin
         irw = 1; sb = 2'b01; pcw = 1;
      end else if (c == 1) begin
         sb = 2'b11; sz = 1; ill = (kind == K_ILL);
      end else begin
         case (kind)
            K_LW, K_SW: begin
               if (c == 2) begin sa = 1; sb = 2'b10; sz = 1; end
               else if (kind == K_SW) begin io = 1; mw = 1; end
               else if (c == 3) begin io = 1; mdw = 1; end
               else begin m2r = 1; rw = 1; end
            end
            K_R: begin
               if (c == 2) begin
                  sa = 1;
                  case (f)
                     6'h22, 6'h23: ao = 1;
                     6'h24: ao = 4;
                     6'h25: ao = 5;
                     6'h26: ao = 7;
                     6'h27: ao = 6;
                     6'h2A: ao = 2;
                     6'h2B: ao = 3;
                     default: ao = 0;
                  endcase
               end else begin rd = 1; rw = 1; end
            end
            K_I: begin
               if (c == 2) begin
                  sa = 1; sb = 2'b10;
                  sz = (o == 6'h08 || o == 6'h0A);
                  case (o)
                     6'h0A: ao = 2;
                     6'h0B: ao = 3;
                     6'h0C: ao = 4;
                     6'h0D: ao = 5;
                     6'h0E: ao = 7;
                     6'h0F: ao = 8;
                     default: ao = 0;
                  endcase
               end else rw = 1;
            end
            default: begin
               sa = 1; ao = 1; pcs = 1;
               pcw = (o == 6'h04) ? z : ~z;
            end
         endcase
      end
      if (rst) begin pcw = 0; mw = 0; irw = 0; mdw = 0; rw = 0; ill = 0; end
      return {pcw, io, mw, irw, mdw, rd, m2r, rw, sa, sb, pcs, sz, ao, ill};
   endfunction

   // Run one instruction; rst_at >= 0 asserts reset during that cycle and abandons it.
   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                            input int rst_at);
      int kind = classify(iop, ifn);
      int n = n_cycles(kind);
      logic [17:0] obs, exp_v;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         reset    = (c == rst_at);
         op       = (c == 0) ? 6'($urandom) : iop;
         func     = (c == 0) ? 6'($urandom) : ifn;
         alu_zero = (kind == K_BR && c == 2) ? iz : 1'($urandom);
         #1;
         if (c == 0) begin
            checks++;
            assert (state === ST_FETCH) else begin
               errors++;
               $error("FAIL fetch_state op=%h observed %0d expected %0d", iop, state, ST_FETCH);
            end
            checks++;
            assert (retired === exp_ret) else begin
               errors++;
               $error("FAIL retired op=%h observed %0d expected %0d", iop, retired, exp_ret);
            end
         end
         obs   = {pc_write, iord, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, pc_src, sz_en, alu_op, illegal};
         exp_v = expect_vec(kind, c, iop, ifn, iz, c == rst_at);
         checks++;
         assert (obs === exp_v) else begin
            errors++;
            $error("FAIL ctrl op=%h func=%h cyc=%0d rst=%0d observed %h expected %h",
                   iop, ifn, c, c == rst_at, obs, exp_v);
         end
         if (c == rst_at) break;
      end
      if (rst_at >= 0 && rst_at < n) exp_ret = '0;
      else if (kind != K_ILL) exp_ret = exp_ret + 1'b1;
   endtask

   initial begin
      r_funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      i_ops   = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      reset = 1'b1; op = 6'h23; func = 6'h20; alu_zero = 1'b0;
      repeat (3) begin
         @(negedge clk);
         op = 6'($urandom);
         #1;
         checks++;
         assert ({pc_write, ir_write, mdr_write, mem_write, reg_write, illegal} === 6'b0) else begin
            errors++;
            $error("FAIL reset_enables observed %b expected 000000",
                   {pc_write, ir_write, mdr_write, mem_write, reg_write, illegal});
         end
      end

      run_instr(6'h00, 6'h20, 1'b0, -1);   // add
      run_instr(6'h23, 6'h00, 1'b0, -1);   // lw
      run_instr(6'h2B, 6'h00, 1'b0, -1);   // sw
      run_instr(6'h04, 6'h00, 1'b1, -1);   // beq taken
      run_instr(6'h05, 6'h00, 1'b1, -1);   // bne not taken
      run_instr(6'h04, 6'h00, 1'b0, -1);   // beq not taken
      run_instr(6'h3F, 6'h00, 1'b0, -1);   // illegal op
      run_instr(6'h00, 6'h00, 1'b0, -1);   // illegal func
      run_instr(6'h2B, 6'h00, 1'b0, 3);    // reset in MEMWR

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0: run_instr(6'h23, 6'($urandom), 1'b0, -1);
            1: run_instr(6'h2B, 6'($urandom), 1'b0, -1);
            2, 3: run_instr(6'h00, r_funcs[$urandom_range(0, 9)], 1'b0, -1);
            4, 5: run_instr(i_ops[$urandom_range(0, 7)], 6'($urandom), 1'b0, -1);
            6: run_instr(6'h04, 6'($urandom), 1'($urandom), -1);
            7: run_instr(6'h05, 6'($urandom), 1'($urandom), -1);
            8: run_instr(6'($urandom), 6'($urandom), 1'($urandom), -1);
            default: run_instr(6'h00, 6'($urandom), 1'b0, -1);
         endcase
      end

      run_instr(6'h23, 6'h00, 1'b0, 2);    // reset in MEMADR
      run_instr(6'h00, 6'h2A, 1'b0, -1);
      run_instr(6'h0F, 6'h00, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
